// File: rtl/dbgsel_pkg.sv
// Shared definitions for the dbgsel debug mux network and its scanner.
// Contents:
//   DBGSEL_W        select code width used by the mux modules
//   DBGSEL_LAT_DEF  default select-to-data pipeline latency
//   DBGSEL_CNT_W    settle counter width (covers latencies 0..15)
//   dbgsel_state_e  scanner FSM states
package dbgsel_pkg;

  localparam int unsigned DBGSEL_W       = 8;
  localparam int unsigned DBGSEL_LAT_DEF = 2;
  localparam int unsigned DBGSEL_CNT_W   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StHold
  } dbgsel_state_e;

endpackage

// File: rtl/dbgsel_scan_wait.sv
// Loadable down-counter used for fixed-latency settle waits.
// Ports:
//   clk   clock (posedge)
//   rst   asynchronous active-high reset, clears the count
//   load  load val into the counter (takes priority over counting)
//   val   value to load
//   zero  high while the count is zero
// The counter decrements by one per cycle until it reaches zero and then holds.
module dbgsel_scan_wait
  import dbgsel_pkg::*;
#(
  parameter int unsigned CW = DBGSEL_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] val,
  output logic          zero
);

  localparam logic [CW-1:0] One = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - One;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dbgsel_scan.sv
// Debug-select scanner: walks a registered select code over an inclusive range
// [lo, hi], waits LAT+1 cycles per code for the mux network to settle, captures
// the returned debug data and presents one (select, data) sample per code on a
// valid/ready stream.
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   start, abort             begin a scan (IDLE only); terminate an active scan
//   lo, hi                   inclusive code range, sampled on an accepted start
//   sel_o                    registered select to the mux network
//   dbg_data                 OR-combined data returned by the network
//   out_valid/out_ready      sample stream handshake
//   out_sel, out_data        sample contents
//   busy, done, err          status; done/err are single-cycle pulses
// Build option: DBGSEL_SCAN_SKIPZERO_EN suppresses samples whose captured data
// is zero; the scan advances as if the sample had been accepted immediately.
module dbgsel_scan
  import dbgsel_pkg::*;
#(
  parameter int unsigned SW  = DBGSEL_W,
  parameter int unsigned DW  = 8,
  parameter int unsigned LAT = DBGSEL_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [SW-1:0] lo,
  input  logic [SW-1:0] hi,
  output logic [SW-1:0] sel_o,
  input  logic [DW-1:0] dbg_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_sel,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [DBGSEL_CNT_W-1:0] LatVal = DBGSEL_CNT_W'(LAT);
  localparam logic [SW-1:0]           SelOne = SW'(1);

  dbgsel_state_e state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] hi_q, hi_d;
  logic          valid_q, valid_d;
  logic [SW-1:0] osel_q, osel_d;
  logic [DW-1:0] odata_q, odata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          cnt_load;
  logic          cnt_zero;
  logic          advance;

  dbgsel_scan_wait #(
    .CW(DBGSEL_CNT_W)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .val  (LatVal),
    .zero (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    hi_d     = hi_q;
    valid_d  = valid_q;
    osel_d   = osel_q;
    odata_d  = odata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    advance  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (hi < lo) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            sel_d    = lo;
            hi_d     = hi;
            cnt_load = 1'b1;
            state_d  = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_zero) begin
`ifdef DBGSEL_SCAN_SKIPZERO_EN
          if (dbg_data == '0) begin
            advance = 1'b1;
          end else begin
            odata_d = dbg_data;
            osel_d  = sel_q;
            valid_d = 1'b1;
            state_d = StHold;
          end
`else
          odata_d = dbg_data;
          osel_d  = sel_q;
          valid_d = 1'b1;
          state_d = StHold;
`endif
        end
      end
      StHold: begin
        if (out_ready) begin
          valid_d = 1'b0;
          advance = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Compare before incrementing so hi = all-ones finishes without wrapping.
    if (advance) begin
      if (sel_q == hi_q) begin
        done_d  = 1'b1;
        state_d = StIdle;
      end else begin
        sel_d    = sel_q + SelOne;
        cnt_load = 1'b1;
        state_d  = StWait;
      end
    end

    // Abort overrides everything, including a same-cycle handshake.
    if (abort && (state_q != StIdle)) begin
      valid_d  = 1'b0;
      done_d   = 1'b1;
      err_d    = 1'b1;
      sel_d    = sel_q;
      cnt_load = 1'b0;
      state_d  = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      hi_q    <= '0;
      valid_q <= 1'b0;
      osel_q  <= '0;
      odata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      hi_q    <= hi_d;
      valid_q <= valid_d;
      osel_q  <= osel_d;
      odata_q <= odata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign sel_o     = sel_q;
  assign out_valid = valid_q;
  assign out_sel   = osel_q;
  assign out_data  = odata_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dbgsel_scan.sv
// Self-checking bench for dbgsel_scan (SW=8, DW=8, LAT=2). A two-flop model of
// the mux network returns a per-mode function of sel_o. Range scans come from
// a vector table; backpressure, abort, start+abort and mid-scan reset are
// hand-written sequences.
module tb_dbgsel_scan;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, out_ready;
  logic [7:0] lo, hi, sel_o, dbg_data, out_sel, out_data;
  logic       out_valid, busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;

  logic [7:0] d1 = 8'd0;
  logic [7:0] d2 = 8'd0;

  always #5 clk = ~clk;

  dbgsel_scan #(
    .SW (8),
    .DW (8),
    .LAT(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .lo       (lo),
    .hi       (hi),
    .sel_o    (sel_o),
    .dbg_data (dbg_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sel  (out_sel),
    .out_data (out_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  function automatic logic [7:0] model(input int m, input logic [7:0] s);
    case (m)
      0:       return s + 8'd1;
      1:       return s ^ 8'hA5;
      default: return (s >= 8'd34 && s <= 8'd64) ? s : 8'd0;
    endcase
  endfunction

  // Two register stages between sel_o and the settled data.
  always @(posedge clk) begin
    d1 <= model(mode, sel_o);
    d2 <= d1;
  end
  assign dbg_data = d2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int lo;
    int hi;
    int mode;
    int exp_n;
    int exp_done;
    int exp_err;
    int exp_first_sel;
    int exp_first_data;
  } vec_t;

  vec_t vecs[5];

  task automatic do_scan(input vec_t v);
    logic [7:0] prev_sel;
    int         cnt;
    bit         got_done;
    lo       = 8'(v.lo);
    hi       = 8'(v.hi);
    mode     = v.mode;
    prev_sel = sel_o;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    if (v.exp_n == 0) begin
      check("illegal done", done, 1);
      check("illegal err", err, 1);
      check("illegal busy", busy, 0);
      check("illegal valid", out_valid, 0);
      check("illegal sel_o held", sel_o, prev_sel);
      tick();
      check("illegal done pulse", done, 0);
      check("illegal busy after", busy, 0);
      return;
    end
    check("scan busy at start", busy, 1);
    check("scan sel_o=lo", sel_o, v.lo);
    cnt      = 0;
    got_done = 0;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      tick();
      if (out_valid) begin
        if (cnt == 0) begin
          check("first sample sel", out_sel, v.exp_first_sel);
          check("first sample data", out_data, v.exp_first_data);
        end
        check("sample data", out_data, model(v.mode, out_sel));
        if (v.mode != 2) check("sample spacing", cyc, cnt * (LAT + 2) + LAT + 1);
        cnt++;
      end
      if (done) begin
        check("done cycle", cyc, v.exp_done);
        check("done err", err, v.exp_err);
        check("busy at done", busy, 0);
        check("sample count", cnt, v.exp_n);
        check("sel_o parked", sel_o, v.hi);
        got_done = 1;
        break;
      end
    end
    if (!got_done) check("done timeout", 0, 1);
  endtask

  initial begin
    vecs[0] = '{lo: 34, hi: 36, mode: 0, exp_n: 3, exp_done: 12, exp_err: 0,
                exp_first_sel: 34, exp_first_data: 35};
    vecs[1] = '{lo: 95, hi: 84, mode: 0, exp_n: 0, exp_done: 0, exp_err: 1,
                exp_first_sel: 0, exp_first_data: 0};
    vecs[2] = '{lo: 254, hi: 255, mode: 1, exp_n: 2, exp_done: 8, exp_err: 0,
                exp_first_sel: 254, exp_first_data: 'h5B};
    vecs[3] = '{lo: 0, hi: 0, mode: 0, exp_n: 1, exp_done: 4, exp_err: 0,
                exp_first_sel: 0, exp_first_data: 1};
`ifdef DBGSEL_SCAN_SKIPZERO_EN
    // 31 kept codes at 4 cycles each, 10 zero codes at 3 cycles each.
    vecs[4] = '{lo: 30, hi: 70, mode: 2, exp_n: 31, exp_done: 154, exp_err: 0,
                exp_first_sel: 34, exp_first_data: 34};
`else
    vecs[4] = '{lo: 30, hi: 70, mode: 2, exp_n: 41, exp_done: 164, exp_err: 0,
                exp_first_sel: 30, exp_first_data: 0};
`endif

    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    lo        = 8'd0;
    hi        = 8'd0;
    #12;
    check("reset sel_o", sel_o, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_sel", out_sel, 0);
    check("reset out_data", out_data, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      do_scan(vecs[i]);
      tick();
    end

    // Backpressure: single code held for five cycles with ready low.
    begin
      bit seen;
      mode      = 0;
      out_ready = 1'b0;
      lo        = 8'd84;
      hi        = 8'd84;
      start     = 1'b1;
      tick();
      start = 1'b0;
      seen  = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (out_valid) begin
          seen = 1;
          break;
        end
      end
      check("bp valid seen", seen, 1);
      for (int i = 0; i < 5; i++) begin
        check("bp valid held", out_valid, 1);
        check("bp sel held", out_sel, 84);
        check("bp data held", out_data, 85);
        check("bp no done", done, 0);
        if (i < 4) tick();
      end
      out_ready = 1'b1;
      tick();
      check("bp valid cleared", out_valid, 0);
      check("bp done", done, 1);
      check("bp err", err, 0);
      tick();
      check("bp done one cycle", done, 0);
    end

    // Abort in HOLD with ready asserted in the same cycle.
    begin
      bit seen;
      out_ready = 1'b0;
      lo        = 8'd10;
      hi        = 8'd20;
      start     = 1'b1;
      tick();
      start = 1'b0;
      seen  = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (out_valid) begin
          seen = 1;
          break;
        end
      end
      check("abort valid seen", seen, 1);
      abort     = 1'b1;
      out_ready = 1'b1;
      tick();
      abort = 1'b0;
      check("abort valid dropped", out_valid, 0);
      check("abort done", done, 1);
      check("abort err", err, 1);
      check("abort busy", busy, 0);
      check("abort sel_o held", sel_o, 10);
      tick();
      check("abort done one cycle", done, 0);
      check("abort no late valid", out_valid, 0);
    end

    // start together with abort in IDLE: start wins.
    begin
      bit got;
      lo    = 8'd5;
      hi    = 8'd6;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("start+abort busy", busy, 1);
      check("start+abort sel_o", sel_o, 5);
      got = 0;
      for (int i = 0; i < 50; i++) begin
        tick();
        if (done) begin
          got = 1;
          check("start+abort err", err, 0);
          check("start+abort final sel", sel_o, 6);
          break;
        end
      end
      check("start+abort done seen", got, 1);
    end

    // Asynchronous reset while in WAIT.
    begin
      bit seen_done;
      tick();
      lo    = 8'd40;
      hi    = 8'd50;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("pre-reset busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("async reset sel_o", sel_o, 0);
      check("async reset busy", busy, 0);
      check("async reset out_valid", out_valid, 0);
      check("async reset out_sel", out_sel, 0);
      check("async reset out_data", out_data, 0);
      check("async reset done", done, 0);
      check("async reset err", err, 0);
      #1 rst = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (done || out_valid) seen_done = 1;
      end
      check("no done after reset", seen_done, 0);
      check("idle after reset", busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
